// File: rtl/seq_alu.sv
// Registered ALU: single-cycle logic/add/shift ops, iterative MUL/DIVU/REMU (WIDTH cycles).
// Latency 1 (single-cycle ops) or WIDTH+1 (iterative); start is ignored while busy.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;
    localparam logic [3:0] OP_REMU = 4'b1110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_nx;
    logic [3:0]             op_q;
    logic [SHW-1:0]         cnt;
    logic [2*WIDTH-1:0]     acc, mcand, acc_nx;
    logic [WIDTH-1:0]       mplier;
    logic [WIDTH-1:0]       rem, quo, divisor, rem_nx, quo_nx;
    logic [WIDTH:0]         trial, diff, sum;
    logic                   ge;
    logic [WIDTH-1:0]       b_eff, alu_res, iter_res;
    logic                   alu_c, alu_v;
    logic                   accept, multi_op, last_iter;

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign accept    = start && (state != RUN);
    assign multi_op  = (ALU_control == OP_MUL) || (ALU_control == OP_DIVU) || (ALU_control == OP_REMU);
    assign last_iter = (state == RUN) && (cnt == SHW'(WIDTH - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? (multi_op ? RUN : DONE) : IDLE;
            RUN:        if (last_iter) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // SUB shares the adder as A + ~B + 1; overflow test then matches ADD's on the effective operand.
    always_comb begin
        b_eff   = (ALU_control == OP_SUB) ? ~B : B;
        sum     = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (ALU_control == OP_SUB)};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALU_control)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (A[WIDTH-1] == b_eff[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_NOT:  alu_res = ~A;
            OP_SLL:  alu_res = A << B[SHW-1:0];
            OP_SRL:  alu_res = A >> B[SHW-1:0];
            OP_SRA:  alu_res = $signed(A) >>> B[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    // One shift-add step and one restoring-division step per RUN cycle.
    always_comb begin
        acc_nx   = acc + (mplier[0] ? mcand : '0);
        trial    = {rem, quo[WIDTH-1]};
        diff     = trial - {1'b0, divisor};
        ge       = (trial >= {1'b0, divisor});
        rem_nx   = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nx   = {quo[WIDTH-2:0], ge};
        case (op_q)
            OP_MUL:  iter_res = acc_nx[WIDTH-1:0];
            OP_DIVU: iter_res = quo_nx;
            default: iter_res = rem_nx;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
            zero     <= 1'b1;
        end else if (accept) begin
            if (multi_op) begin
                op_q    <= ALU_control;
                cnt     <= '0;
                acc     <= '0;
                mcand   <= {{WIDTH{1'b0}}, A};
                mplier  <= B;
                rem     <= '0;
                quo     <= A;
                divisor <= B;
            end else begin
                result   <= alu_res;
                carry    <= alu_c;
                overflow <= alu_v;
                negative <= alu_res[WIDTH-1];
                zero     <= (alu_res == '0);
            end
        end else if (state == RUN) begin
            cnt    <= cnt + SHW'(1);
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_nx;
            quo    <= quo_nx;
            if (last_iter) begin
                result   <= iter_res;
                carry    <= 1'b0;
                overflow <= 1'b0;
                negative <= iter_res[WIDTH-1];
                zero     <= (iter_res == '0);
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vector table, hand sequences for multi-cycle corners, random vs model.
module tb_seq_alu;
    logic        clk, rst, start;
    logic [3:0]  ALU_control;
    logic [31:0] A, B;
    logic        busy, done, carry, overflow, negative, zero;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    seq_alu dut (
        .clk(clk), .rst(rst), .start(start), .ALU_control(ALU_control),
        .A(A), .B(B), .busy(busy), .done(done), .result(result),
        .carry(carry), .overflow(overflow), .negative(negative), .zero(zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, res;
        logic        c, v, n, z;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one op and wait (bounded) for done; optional disturbance of inputs mid-run.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, output int lat, output int busy_cnt);
        start = 1'b1; ALU_control = op; A = a; B = b;
        lat = 0; busy_cnt = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
            if (disturb && lat == 5) begin
                start = 1'b1; A = $urandom; B = $urandom; ALU_control = 4'b0001;
            end else begin
                start = 1'b0;
            end
        end while (!done && lat < 100);
    endtask

    // Reference model from plain arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic c, output logic v, output int lat);
        longint s;
        logic [63:0] p;
        int sh;
        sh = int'(b % 32);
        r = '0; c = 1'b0; v = 1'b0; lat = 1; s = 0;
        case (op)
            4'b0001: begin
                r = a + b;
                c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s != longint'($signed(r)));
            end
            4'b1001: begin
                r = a - b;
                c = (a >= b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s != longint'($signed(r)));
            end
            4'b0100: r = a & b;
            4'b0011: r = a | b;
            4'b0101: r = a ^ b;
            4'b0110: r = ~a;
            4'b0111: r = a << sh;
            4'b1000: r = a >> sh;
            4'b1010: r = $signed(a) >>> sh;
            4'b1100: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; lat = 33; end
            4'b1101: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = 33; end
            4'b1110: begin r = (b == 0) ? a : a % b; lat = 33; end
            default: r = '0;
        endcase
    endtask

    initial begin
        int lat, bcnt;
        logic [31:0] er, ra, rb;
        logic ec, ev;
        logic [3:0] rop;
        int elat;

        rst = 1'b1; start = 1'b0; ALU_control = '0; A = '0; B = '0;
        #2;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_result", {32'd0, result}, 64'd0);
        chk("reset_flags", {60'd0, carry, overflow, negative, zero}, 64'h1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        tbl.push_back('{4'b0001, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0, 1'b0, 1});
        tbl.push_back('{4'b0001, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1, 1'b1, 1'b0, 1});
        tbl.push_back('{4'b1001, 32'd5,          32'd5,          32'd0,          1'b1, 1'b0, 1'b0, 1'b1, 1});
        tbl.push_back('{4'b0001, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1'b0, 1'b1, 1});
        tbl.push_back('{4'b1001, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b0, 1'b1, 1'b0, 1});
        tbl.push_back('{4'b1001, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b1, 1'b1, 1'b0, 1'b0, 1});
        tbl.push_back('{4'b0110, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0, 1'b1, 1'b0, 1});
        tbl.push_back('{4'b0100, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1'b0, 1'b0, 1'b0, 1});
        tbl.push_back('{4'b0011, 32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF,  1'b0, 1'b0, 1'b0, 1'b0, 1});
        tbl.push_back('{4'b0101, 32'hFFFF_0000,  32'hFF00_FF00,  32'h00FF_FF00,  1'b0, 1'b0, 1'b0, 1'b0, 1});
        tbl.push_back('{4'b1010, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 1'b0, 1'b1, 1'b0, 1});
        tbl.push_back('{4'b1000, 32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 1'b0, 1'b0, 1'b0, 1});
        tbl.push_back('{4'b0111, 32'd1,          32'd33,         32'd2,          1'b0, 1'b0, 1'b0, 1'b0, 1});
        tbl.push_back('{4'b0000, 32'd5,          32'd7,          32'd0,          1'b0, 1'b0, 1'b0, 1'b1, 1});
        tbl.push_back('{4'b1100, 32'h0001_2345,  32'h0000_0100,  32'h0123_4500,  1'b0, 1'b0, 1'b0, 1'b0, 33});
        tbl.push_back('{4'b1101, 32'd100,        32'd7,          32'd14,         1'b0, 1'b0, 1'b0, 1'b0, 33});
        tbl.push_back('{4'b1110, 32'd100,        32'd7,          32'd2,          1'b0, 1'b0, 1'b0, 1'b0, 33});
        tbl.push_back('{4'b1101, 32'd9,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0, 1'b1, 1'b0, 33});
        tbl.push_back('{4'b1110, 32'd9,          32'd0,          32'd9,          1'b0, 1'b0, 1'b0, 1'b0, 33});

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, lat, bcnt);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
            chk($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(tbl[i].lat - 1));
            chk($sformatf("vec%0d_result", i), {32'd0, result}, {32'd0, tbl[i].res});
            chk($sformatf("vec%0d_flags_cvnz", i), {60'd0, carry, overflow, negative, zero},
                {60'd0, tbl[i].c, tbl[i].v, tbl[i].n, tbl[i].z});
        end

        // done is a single-cycle pulse when no new start follows
        @(posedge clk); #1;
        chk("done_pulse_clears", {63'd0, done}, 64'd0);
        chk("result_holds", {32'd0, result}, {32'd0, 32'd9});

        // start and operand changes during RUN are ignored
        run_op(4'b1100, 32'h0001_2345, 32'h0000_0100, 1'b1, lat, bcnt);
        chk("mul_disturb_latency", 64'(lat), 64'd33);
        chk("mul_disturb_busy", 64'(bcnt), 64'd32);
        chk("mul_disturb_result", {32'd0, result}, 64'h0123_4500);

        // reset in the middle of a division aborts it
        run_op(4'b0001, 32'd3, 32'd4, 1'b0, lat, bcnt);
        chk("pre_abort_result", {32'd0, result}, 64'd7);
        start = 1'b1; ALU_control = 4'b1101; A = 32'd100; B = 32'd7;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_result", {32'd0, result}, 64'd0);
        chk("abort_zero", {63'd0, zero}, 64'd1);
        @(posedge clk); @(posedge clk); #1;
        chk("abort_no_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        run_op(4'b0001, 32'd5, 32'd7, 1'b0, lat, bcnt);
        chk("post_abort_latency", 64'(lat), 64'd1);
        chk("post_abort_result", {32'd0, result}, 64'd12);

        // random operations against the model
        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 300)));
            if (($urandom_range(0, 3) == 0) && (rop == 4'b1101 || rop == 4'b1110)) ra = 32'($urandom_range(0, 1000));
            model(rop, ra, rb, er, ec, ev, elat);
            run_op(rop, ra, rb, 1'b0, lat, bcnt);
            chk($sformatf("rnd%0d_op%0h_latency", i, rop), 64'(lat), 64'(elat));
            chk($sformatf("rnd%0d_op%0h_a%0h_b%0h_result", i, rop, ra, rb), {32'd0, result}, {32'd0, er});
            chk($sformatf("rnd%0d_op%0h_flags_cvnz", i, rop), {60'd0, carry, overflow, negative, zero},
                {60'd0, ec, ev, er[31], (er == 32'd0)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the single-cycle CPU's combinational ALU. It keeps the existing 4-bit `ALU_control` encoding and flag set, adds shifts and an overflow flag, and adds iterative unsigned multiply, divide and remainder. A start/done handshake lets the control unit stall on multi-cycle operations. It sits in the execute stage between the register-file read ports and the writeback mux.

## Interface
- `WIDTH`, default 32: operand/result width. Must be a power of two, at least 8.
- `SHW`, default $clog2(WIDTH): shift-amount width. Derived; do not override.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request; sampled only when the block is not busy.
- `ALU_control` in 4: operation code.
- `A` in WIDTH: operand A.
- `B` in WIDTH: operand B.
- `busy` out 1: multi-cycle operation in progress.
- `done` out 1: one-cycle pulse; `result` and flags are valid from this cycle.
- `result` out WIDTH: registered result.
- `carry` out 1: ADD carry-out or SUB no-borrow; 0 for all other ops.
- `overflow` out 1: signed overflow for ADD/SUB; 0 for all other ops.
- `negative` out 1: `result[WIDTH-1]`.
- `zero` out 1: high when `result` is 0.

## Operation
- Opcodes:
  - 0001 ADD; 1001 SUB (A + ~B + 1).
  - 0100 AND; 0011 OR; 0101 XOR; 0110 NOT A.
  - 0111 SLL; 1000 SRL; 1010 SRA. Shift amount is `B[SHW-1:0]`.
  - 1100 MUL: low WIDTH bits of the unsigned product.
  - 1101 DIVU: unsigned quotient.
  - 1110 REMU: unsigned remainder.
  - Any other code: `result` = 0, flags 0 except `zero` = 1; completes as a single-cycle op.
- State machine: IDLE, RUN, DONE.
  - IDLE/DONE with `start`=1 and a single-cycle op: compute, register outputs, go to DONE.
  - IDLE/DONE with `start`=1 and MUL/DIVU/REMU: latch A, B and op; clear the iteration counter; go to RUN.
  - RUN: one iteration per cycle. After WIDTH iterations, register outputs and go to DONE.
  - DONE with `start`=0: go to IDLE.
- MUL: shift-add, one multiplier bit per cycle, LSB first. Accumulator is 2*WIDTH bits; only the low half is returned.
- DIVU/REMU: restoring division, one quotient bit per cycle, MSB first.
- Divide by zero: quotient all ones, remainder = A. Still takes the full WIDTH iterations.
- `start` while in RUN: ignored. Operands and op were latched at acceptance, so input changes during RUN have no effect.
- `done` = 1 exactly in DONE. `busy` = 1 exactly in RUN.
- `result` and flags hold their last value until the next completion.
- `overflow` for ADD: operands have the same sign and the result sign differs. For SUB: operands have different signs and the result sign differs from A's.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `carry`=0, `overflow`=0, `negative`=0, `zero`=1.
- `rst` asserted mid-RUN aborts the operation immediately; no `done` is produced.
- Single-cycle ops: `start` sampled at edge N; `done` and outputs valid after edge N+1 (latency 1). Back-to-back starts give one result per cycle.
- Multi-cycle ops: `start` at edge N; `busy` high after edges N+1 through N+WIDTH; `done` after edge N+WIDTH+1 (latency WIDTH+1, i.e. 33 for WIDTH=32).
- `start` in DONE is accepted in the same cycle as the `done` pulse, with no idle bubble.

## Test plan
- Reset: drive `rst` with no clock edges -> all outputs at their reset values, `zero`=1. Release, `start` ADD A=5 B=7 -> `done` after 1 cycle, `result`=12, `carry`=0.
- Flags: ADD 0x7FFFFFFF+1 -> 0x80000000, `overflow`=1, `negative`=1. SUB 5-5 -> 0, `zero`=1, `carry`=1. ADD 0xFFFFFFFF+1 -> 0, `carry`=1.
- Logic and shifts: NOT 0 -> 0xFFFFFFFF. SRA 0x80000000 by 4 -> 0xF8000000. SLL 1 by B=33 -> 2 (shift amount taken mod 32).
- MUL 0x12345 × 0x100 -> 0x01234500, `done` exactly 33 cycles after start, `busy` high for 32 cycles. While busy, change A/B and pulse `start` -> no effect.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
- Assert `rst` at cycle 10 of a DIVU -> `busy`=0 immediately, no `done`, `result`=0. A following ADD completes normally.
